ps2_key_filter: RTL and testbench
=================================

// Module: ps2_key_filter
// PURPOSE
//  Sits between the PS/2 byte receiver and the scan-code-to-ASCII decoder.
//  Watches the received byte stream, keeps only the key code that follows a
//  break prefix (0xF0), and buffers those codes in a small first-word-fall-through
//  FIFO. Each key release therefore yields exactly one code; make codes and
//  typematic repeats are dropped.
// PARAMETERS
//  W_SIZE    2      FIFO address width; depth = 2**W_SIZE entries of 8 bits
//  BRK_CODE  8'hF0  break prefix byte
//  EXT_CODE  8'hE0  extended prefix byte; always ignored
// PORTS
//  clk           in   1  system clock
//  reset_n       in   1  synchronous reset, active low
//  rx_done_tick  in   1  one-cycle strobe from PS/2 receiver: rx_data valid
//  rx_data       in   8  received byte
//  rd_key_code   in   1  pop request; head entry is removed at this clock edge
//  key_code      out  8  FIFO head (FWFT); valid only while kb_buf_empty==0
//  kb_buf_empty  out  1  FIFO holds no codes
//  kb_buf_full   out  1  FIFO holds 2**W_SIZE codes
//  overflow      out  1  sticky: a break code was dropped because the FIFO was full
//  clr_overflow  in   1  clears overflow (one cycle)
// BEHAVIOUR
//  - Reset (reset_n==0 at a clk edge): state=WAIT_BRK, FIFO emptied, overflow=0.
//    Resulting outputs: kb_buf_empty=1, kb_buf_full=0, key_code=8'h00.
//    Reset mid-sequence discards any pending break prefix.
//  - FSM, evaluated only on cycles where rx_done_tick==1:
//    WAIT_BRK: rx_data==BRK_CODE -> GET_CODE. Any other byte, including
//              EXT_CODE and make codes, is ignored; state stays WAIT_BRK.
//    GET_CODE: rx_data==BRK_CODE -> stay in GET_CODE (repeated prefix).
//              rx_data==EXT_CODE -> stay in GET_CODE (E0 F0 xx and F0 E0 xx
//              both yield xx). Any other byte -> issue a write of rx_data and
//              go to WAIT_BRK.
//    With rx_done_tick==0 the state holds; there is no timeout.
//  - Write latency: data is written at the edge where the GET_CODE byte is
//    strobed. kb_buf_empty falls and key_code is valid in the next cycle.
//  - Writing while full (and no pop in the same cycle): the code is dropped,
//    FIFO contents are unchanged, overflow<=1, FSM still returns to WAIT_BRK.
//  - Pop: rd_key_code while not empty advances the head at the edge.
//    rd_key_code while empty is ignored (no pointer change, no error).
//  - Simultaneous write and pop:
//    - when full: both take effect; full stays 1; no overflow.
//    - when empty: the pop is ignored and the write is accepted.
//    - otherwise: both take effect and the count is unchanged.
//  - overflow: set has priority over clr_overflow in the same cycle.
//  - Pointers are W_SIZE bits and wrap modulo 2**W_SIZE. Full and empty are
//    derived from registered flags, not from pointer comparison alone.
//  - All outputs are registered or driven directly from registers plus the
//    FIFO RAM read mux. There is no combinational path from rx_* to any output.
// STRUCTURE
//  - ps2_pkg: BRK_CODE and EXT_CODE localparams; state_t enum {WAIT_BRK, GET_CODE}.
//  - One sub-module: sync_fifo #(B=8, W=W_SIZE). It is generic FWFT with
//    registered full/empty and has the same clk/reset_n convention.
//  - The top level holds only the FSM, the write-enable generation and the
//    overflow flag.
// TESTING
//  1 Bytes 1C,F0,1C -> exactly one entry 1C; no write on the first 1C;
//    kb_buf_empty=0 one cycle after the third strobe.
//  2 Bytes E0,F0,75 and F0,E0,6B -> entries 75 then 6B in order; E0 never stored.
//  3 W_SIZE=2, five releases 16,1E,26,25,2E with no pops -> full=1 after four,
//    2E dropped, overflow=1; pops return 16,1E,26,25; clr_overflow clears it.
//  4 Full FIFO, pop and a new break code on the same edge -> full stays 1,
//    overflow stays 0, head advances, new code at tail.
//  5 rd_key_code pulsed while empty -> no change. Then one write followed by a
//    pop with a simultaneous write: count goes 1 -> 1 with the correct order.
//  6 Send F0, assert reset_n=0 for one cycle, then send 1C -> nothing stored;
//    then F0,29 -> single entry 29.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 key-release filter.
package ps2_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic {
    WAIT_BRK = 1'b0,
    GET_CODE = 1'b1
  } state_t;

endpackage

// File: rtl/ps2_key_filter_if.sv
// Byte-stream input, pop handshake and FIFO status of the key-release filter.
interface ps2_key_filter_if;

  // rx_done_tick qualifies rx_data for one cycle only, and the receiver has
  // no ready input, so no byte can be back-pressured. rd_key_code removes
  // key_code at the next edge only while kb_buf_empty is 0.
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_key_code;
  logic       clr_overflow;
  logic [7:0] key_code;
  logic       kb_buf_empty;
  logic       kb_buf_full;
  logic       overflow;

  modport master (
    output rx_done_tick, rx_data, rd_key_code, clr_overflow,
    input  key_code, kb_buf_empty, kb_buf_full, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, rd_key_code, clr_overflow,
    output key_code, kb_buf_empty, kb_buf_full, overflow
  );

endinterface

// File: rtl/ps2_key_filter_sync_fifo.sv
// Generic first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [B-1:0] w_data_i,
  output logic [B-1:0] r_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem_q [DEPTH];
  logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [W-1:0] w_ptr_nx, r_ptr_nx;
  logic         full_q, full_d, empty_q, empty_d;
  logic         wr_en, rd_en;

  // A write into a full FIFO is only accepted when a pop frees a slot at the same edge.
  assign wr_en    = wr_i && (!full_q || rd_i);
  assign rd_en    = rd_i && !empty_q;
  assign w_ptr_nx = w_ptr_q + 1'b1;
  assign r_ptr_nx = r_ptr_q + 1'b1;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({wr_en, rd_en})
      2'b01: begin
        r_ptr_d = r_ptr_nx;
        full_d  = 1'b0;
        empty_d = (r_ptr_nx == w_ptr_q);
      end
      2'b10: begin
        w_ptr_d = w_ptr_nx;
        empty_d = 1'b0;
        full_d  = (w_ptr_nx == r_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_ptr_nx;
        r_ptr_d = r_ptr_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[w_ptr_q] <= w_data_i;
  end

  // Stale RAM contents are hidden while empty so the head reads as zero.
  assign r_data_o = empty_q ? '0 : mem_q[r_ptr_q];
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/ps2_key_filter.sv
// Keeps only the key code that follows a break prefix and queues it for the decoder.
module ps2_key_filter
  import ps2_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ps2_key_filter_if.slave     bus,
  output state_t              dbg_state_o
);

  state_t state_q, state_d;
  logic   wr_req;
  logic   overflow_q, overflow_d;
  logic   fifo_full;

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    if (bus.rx_done_tick) begin
      case (state_q)
        WAIT_BRK: if (bus.rx_data == BRK_CODE) state_d = GET_CODE;
        GET_CODE: begin
          // Repeated or extended prefixes keep waiting for the actual key code.
          if (bus.rx_data != BRK_CODE && bus.rx_data != EXT_CODE) begin
            wr_req  = 1'b1;
            state_d = WAIT_BRK;
          end
        end
        default: state_d = WAIT_BRK;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_req && fifo_full && !bus.rd_key_code) overflow_d = 1'b1;
    else if (bus.clr_overflow)                   overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= WAIT_BRK;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(.B(8), .W(W_SIZE)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_i     (wr_req),
    .rd_i     (bus.rd_key_code),
    .w_data_i (bus.rx_data),
    .r_data_o (bus.key_code),
    .empty_o  (bus.kb_buf_empty),
    .full_o   (fifo_full)
  );

  assign bus.kb_buf_full = fifo_full;
  assign bus.overflow    = overflow_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Scoreboard bench for ps2_key_filter: release sequences, overflow, pops and reset.
module tb_ps2_key_filter;
  import ps2_pkg::*;

  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   reset_n;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_pass = 0;
  logic [7:0] exp_q[$];
  logic   exp_ovf;

  ps2_key_filter_if bus ();

  ps2_key_filter #(.W_SIZE(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // driver tasks (inputs change on negedge, outputs sampled on negedge)
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] code);
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_release(input logic [7:0] code);
    send_byte(BRK_CODE);
    send_byte(code);
    model_write(code);
  endtask

  task automatic check_flags(input string tag);
    chk_eq({tag, "_empty"}, 32'(bus.kb_buf_empty), 32'(exp_q.size() == 0));
    chk_eq({tag, "_full"},  32'(bus.kb_buf_full),  32'(exp_q.size() == DEPTH));
    chk_eq({tag, "_ovf"},   32'(bus.overflow),     32'(exp_ovf));
  endtask

  task automatic pop_check();
    logic [7:0] h;
    if (exp_q.size() == 0) begin
      chk_eq("pop_none_empty", 32'(bus.kb_buf_empty), 32'd1);
      return;
    end
    h = exp_q.pop_front();
    chk_eq("pop_head", 32'(bus.key_code), 32'(h));
    bus.rd_key_code = 1'b1;
    @(negedge clk);
    bus.rd_key_code = 1'b0;
  endtask

  // pop the head while the final byte of a release is strobed (F0 already sent)
  task automatic pop_write(input logic [7:0] code);
    logic [7:0] h;
    h = exp_q.pop_front();
    chk_eq("pw_head", 32'(bus.key_code), 32'(h));
    bus.rd_key_code  = 1'b1;
    bus.rx_data      = code;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rd_key_code  = 1'b0;
    bus.rx_done_tick = 1'b0;
    exp_q.push_back(code);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_check();
    check_flags(tag);
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rd_key_code  = 1'b0;
    bus.clr_overflow = 1'b0;
    reset_n          = 1'b0;
    exp_ovf          = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // reset state
    check_flags("rst");
    chk_eq("rst_key", 32'(bus.key_code), 32'h00);
    chk_eq("rst_state", 32'(dbg_state), 32'(WAIT_BRK));

    // 1: make code ignored, release stored, one-cycle latency
    send_byte(8'h1C);
    chk_eq("t1_make_ignored", 32'(bus.kb_buf_empty), 32'd1);
    send_byte(BRK_CODE);
    chk_eq("t1_state_get", 32'(dbg_state), 32'(GET_CODE));
    chk_eq("t1_no_write_on_f0", 32'(bus.kb_buf_empty), 32'd1);
    send_byte(8'h1C);
    model_write(8'h1C);
    chk_eq("t1_empty_next", 32'(bus.kb_buf_empty), 32'd0);
    chk_eq("t1_key", 32'(bus.key_code), 32'h1C);
    chk_eq("t1_state_back", 32'(dbg_state), 32'(WAIT_BRK));
    drain("t1");

    // 2: extended prefix in either order
    send_byte(EXT_CODE);
    send_release(8'h75);
    send_byte(BRK_CODE);
    send_byte(EXT_CODE);
    chk_eq("t2_state_after_e0", 32'(dbg_state), 32'(GET_CODE));
    send_byte(8'h6B);
    model_write(8'h6B);
    check_flags("t2");
    drain("t2");

    // 3: overflow with five releases, then clear
    send_release(8'h16);
    send_release(8'h1E);
    send_release(8'h26);
    send_release(8'h25);
    check_flags("t3_four");
    send_release(8'h2E);
    check_flags("t3_five");
    drain("t3_drained");
    @(negedge clk);
    bus.clr_overflow = 1'b1;
    @(negedge clk);
    bus.clr_overflow = 1'b0;
    exp_ovf = 1'b0;
    check_flags("t3_clr");

    // 4: pop and write together while full
    send_release(8'h41);
    send_release(8'h42);
    send_release(8'h43);
    send_release(8'h44);
    send_byte(BRK_CODE);
    pop_write(8'h45);
    check_flags("t4");
    drain("t4");

    // 5: pop while empty is ignored; pop+write with one entry
    bus.rd_key_code = 1'b1;
    @(negedge clk);
    bus.rd_key_code = 1'b0;
    check_flags("t5_empty_pop");
    chk_eq("t5_empty_key", 32'(bus.key_code), 32'h00);
    send_release(8'h33);
    send_byte(BRK_CODE);
    pop_write(8'h34);
    check_flags("t5_count1");
    drain("t5");

    // 6: reset discards a pending break prefix
    send_byte(BRK_CODE);
    do_reset();
    chk_eq("t6_state_rst", 32'(dbg_state), 32'(WAIT_BRK));
    send_byte(8'h1C);
    check_flags("t6_nothing");
    send_release(8'h29);
    check_flags("t6_one");
    drain("t6");

    // random releases with make-code noise and occasional pops
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom_range(8'h01, 8'h7F)));
      send_release(8'($urandom_range(8'h01, 8'h7F)));
      if ($urandom_range(0, 2) == 0) pop_check();
      check_flags("rnd");
    end
    drain("rnd_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
